// File: rtl/gs_butterfly_if.sv
// Sample/result bus for the Gentleman-Sande butterfly.
// The master side drives samples and the slave side returns results.
interface gs_butterfly_if;
    logic        valid_in;
    logic [27:0] x_in;
    logic [27:0] y_in;
    logic        valid_out;
    logic [27:0] x_out;
    logic [27:0] y_out;

    modport master (
        output valid_in, x_in, y_in,
        input  valid_out, x_out, y_out
    );

    modport slave (
        input  valid_in, x_in, y_in,
        output valid_out, x_out, y_out
    );
endinterface

// File: rtl/gs_butterfly.sv
// Inverse-NTT Gentleman-Sande butterfly, q = 2^28 - 2^16 + 1.
// Add/sub stage, 5-cycle modular multiplier, output register.
module gs_butterfly #(
    parameter logic [7:0]        START   = 8'd6,
    parameter logic [31:0][27:0] FACTORS = {32{28'd1}},
    parameter logic              HALVE   = 1'b0
) (
    input logic           clk,
    input logic           rst,
    gs_butterfly_if.slave bus
);

    localparam logic [27:0] Q = 28'hFFF0001;

    // Twiddle sequencing state
    logic [7:0]  cnt;
    logic        seq_en;
    logic [4:0]  idx;
    logic [27:0] w_sel;

    // Stage 1
    logic [28:0] sum_raw;
    logic [27:0] s_c;
    logic [27:0] d_c;
    logic [27:0] s1;
    logic [27:0] d1;
    logic [27:0] w1;

    // Multiplier stages
    logic [55:0] p_m1;
    logic [27:0] h1;
    logic [27:0] l1;
    logic [44:0] f1_c;
    logic [44:0] f1;
    logic [16:0] h2;
    logic [27:0] l2;
    logic [33:0] f2_c;
    logic [33:0] f2;
    logic [5:0]  h3;
    logic [27:0] l3;
    logic [28:0] f3_c;
    logic [28:0] f3;
    logic [27:0] r_c;
    logic [27:0] r5;

    // Sum delay line and valid pipeline
    logic [27:0] s_dly [5];
    logic [5:0]  vp;

    function automatic logic [27:0] halve(input logic [27:0] v);
        logic [28:0] t;
        t = v[0] ? ({1'b0, v} + {1'b0, Q}) : {1'b0, v};
        return HALVE ? t[28:1] : v;
    endfunction

    assign w_sel = seq_en ? FACTORS[idx] : FACTORS[0];

    // Sample counter holds FACTORS[0] until START samples have gone by
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= 8'd0;
            idx    <= 5'd0;
            seq_en <= (START == 8'd0);
        end else if (bus.valid_in) begin
            if (seq_en) begin
                idx <= idx + 5'd1;
            end else begin
                cnt <= cnt + 8'd1;
                if (cnt + 8'd1 == START) begin
                    seq_en <= 1'b1;
                end
            end
        end
    end

    assign sum_raw = {1'b0, bus.x_in} + {1'b0, bus.y_in};
    assign s_c     = (sum_raw >= {1'b0, Q}) ? 28'(sum_raw - {1'b0, Q})
                                            : sum_raw[27:0];
    assign d_c     = bus.x_in - bus.y_in
                   + ((bus.x_in < bus.y_in) ? Q : 28'd0);

    // Stage 1: reduced sum, reduced difference and its twiddle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 28'd0;
            d1 <= 28'd0;
            w1 <= 28'd0;
        end else begin
            s1 <= s_c;
            d1 <= d_c;
            w1 <= w_sel;
        end
    end

    // Fold 2^28 = 2^16 - 1 three times, then one conditional subtract
    assign h1   = p_m1[55:28];
    assign l1   = p_m1[27:0];
    assign f1_c = {1'b0, h1, 16'd0} - {17'd0, h1} + {17'd0, l1};
    assign h2   = f1[44:28];
    assign l2   = f1[27:0];
    assign f2_c = {1'b0, h2, 16'd0} - {17'd0, h2} + {6'd0, l2};
    assign h3   = f2[33:28];
    assign l3   = f2[27:0];
    assign f3_c = {7'd0, h3, 16'd0} - {23'd0, h3} + {1'b0, l3};
    assign r_c  = (f3 >= {1'b0, Q}) ? 28'(f3 - {1'b0, Q}) : f3[27:0];

    // Multiplier: product, three folds, final reduction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_m1 <= 56'd0;
            f1   <= 45'd0;
            f2   <= 34'd0;
            f3   <= 29'd0;
            r5   <= 28'd0;
        end else begin
            p_m1 <= {28'd0, d1} * {28'd0, w1};
            f1   <= f1_c;
            f2   <= f2_c;
            f3   <= f3_c;
            r5   <= r_c;
        end
    end

    // Sum rides alongside the multiplier
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 5; i++) begin
                s_dly[i] <= 28'd0;
            end
        end else begin
            s_dly[0] <= s1;
            for (int i = 1; i < 5; i++) begin
                s_dly[i] <= s_dly[i-1];
            end
        end
    end

    // Valid follows the data; bubbles stay bubbles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vp <= 6'd0;
        end else begin
            vp <= {vp[4:0], bus.valid_in};
        end
    end

    // Output register, held between results
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.valid_out <= 1'b0;
            bus.x_out     <= 28'd0;
            bus.y_out     <= 28'd0;
        end else begin
            bus.valid_out <= vp[5];
            if (vp[5]) begin
                bus.x_out <= halve(s_dly[4]);
                bus.y_out <= halve(r5);
            end
        end
    end

endmodule
